// File: rtl/spi_responder.sv
// spi_responder: converter-side SPI register responder with a 64 x 8 register file, oversampled in clk.
// Optional SPI_RESPONDER_AUTOINC_EN enables multi-byte bursts with 6-bit address autoincrement.
`default_nettype none

module spi_responder #(
    parameter int         FORMAT      = 0,
    parameter logic [6:0] GLOBAL_ADDR = 7'h04,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_mclk,
    input  logic       spi_cs,
    input  logic       spi_mdi,
    output logic       spi_mdo,
    output logic       spi_mdo_oe,
    input  logic [5:0] reg_addr,
    output logic [7:0] reg_rdata,
    output logic       wr_strobe,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] GADDR  = 3'd1;
    localparam logic [2:0] ADDR   = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] IGNORE = 3'd4;

    logic [SYNC_STAGES-1:0] mclk_sync_q, cs_sync_q, mdi_sync_q;
    logic                   mclk_prev_q, cs_prev_q;
    logic                   mclk_s, cs_s, mdi_s;
    logic                   mclk_fall, cs_rise, cs_fall;

    logic [2:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [5:0] addr_q, addr_d;
    logic       rd_q, rd_d;
    logic       mdo_q, mdo_d;
    logic       oe_q, oe_d;
    logic       err_q, err_d;
    logic       strobe_q, strobe_d;
    logic [5:0] wa_q, wa_d;
    logic [7:0] wd_q, wd_d;
    logic       burst_q, burst_d;
    logic [7:0] regs_q [64];

    logic [7:0] rx_byte;
    logic       rd_now;
    logic       we;
    logic [5:0] next_addr;

    assign mclk_s    = mclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mdi_s     = mdi_sync_q[SYNC_STAGES-1];
    assign mclk_fall = mclk_prev_q & ~mclk_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign rx_byte   = {rx_q[6:0], mdi_s};
    assign next_addr = addr_q + 6'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mdi_sync_q  <= '0;
            mclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            mclk_sync_q <= {mclk_sync_q[SYNC_STAGES-2:0], spi_mclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            mdi_sync_q  <= {mdi_sync_q[SYNC_STAGES-2:0], spi_mdi};
            mclk_prev_q <= mclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        mdo_d    = mdo_q;
        oe_d     = oe_q;
        err_d    = err_q;
        strobe_d = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;
        burst_d  = burst_q;
        we       = 1'b0;
        rd_now   = rd_q;

        // Chip-select deassert wins over any coincident clock edge.
        if (cs_fall) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            oe_d    = 1'b0;
            mdo_d   = 1'b0;
            if (state_q == GADDR || state_q == ADDR ||
                (state_q == DATA && (!burst_q || cnt_q != 3'd0))) begin
                err_d = 1'b1;
            end
        end else if (cs_rise && state_q == IDLE) begin
            state_d = (FORMAT == 1) ? GADDR : ADDR;
            cnt_d   = 3'd0;
            burst_d = 1'b0;
            rd_d    = 1'b0;
        end else if (mclk_fall && cs_s && state_q != IDLE && state_q != IGNORE) begin
            cnt_d = cnt_q + 3'd1;
            rx_d  = rx_byte;
            case (state_q)
                GADDR: begin
                    if (cnt_q == 3'd7) begin
                        if (rx_byte[7:1] == GLOBAL_ADDR) begin
                            rd_d    = ~rx_byte[0];
                            state_d = ADDR;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR: begin
                    if (cnt_q == 3'd7) begin
                        if (FORMAT == 0) begin
                            rd_now = rx_byte[7];
                        end
                        rd_d    = rd_now;
                        addr_d  = rx_byte[5:0];
                        state_d = DATA;
                        if (rd_now) begin
                            tx_d  = regs_q[rx_byte[5:0]];
                            mdo_d = regs_q[rx_byte[5:0]][7];
                            oe_d  = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (rd_q) begin
                        if (cnt_q != 3'd7) begin
                            mdo_d = tx_q[6];
                            tx_d  = {tx_q[6:0], 1'b0};
                        end else begin
`ifdef SPI_RESPONDER_AUTOINC_EN
                            tx_d  = regs_q[next_addr];
                            mdo_d = regs_q[next_addr][7];
`else
                            mdo_d = 1'b0;
                            oe_d  = 1'b0;
`endif
                        end
                    end else if (cnt_q == 3'd7) begin
                        we       = 1'b1;
                        strobe_d = 1'b1;
                        wa_d     = addr_q;
                        wd_d     = rx_byte;
                    end
                    if (cnt_q == 3'd7) begin
                        burst_d = 1'b1;
`ifdef SPI_RESPONDER_AUTOINC_EN
                        addr_d  = next_addr;
`else
                        state_d = IGNORE;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            rx_q     <= 8'h00;
            tx_q     <= 8'h00;
            addr_q   <= 6'd0;
            rd_q     <= 1'b0;
            mdo_q    <= 1'b0;
            oe_q     <= 1'b0;
            err_q    <= 1'b0;
            strobe_q <= 1'b0;
            wa_q     <= 6'd0;
            wd_q     <= 8'h00;
            burst_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            mdo_q    <= mdo_d;
            oe_q     <= oe_d;
            err_q    <= err_d;
            strobe_q <= strobe_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            burst_q  <= burst_d;
        end
    end

    // Registered write: a same-clk local read still sees the old contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (we) begin
            regs_q[addr_q] <= rx_byte;
        end
    end

    assign reg_rdata  = regs_q[reg_addr];
    assign spi_mdo    = mdo_q;
    assign spi_mdo_oe = oe_q;
    assign wr_strobe  = strobe_q;
    assign wr_addr    = wa_q;
    assign wr_data    = wd_q;
    assign frame_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_responder.sv
// Scoreboard bench for spi_responder: TI and ADI instances share the SPI clock/data lines, separate chip selects.
`default_nettype none

module tb_spi_responder;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       spi_mclk = 1'b0;
    logic       cs_ti = 1'b0;
    logic       cs_adi = 1'b0;
    logic       spi_mdi = 1'b0;
    logic [5:0] reg_addr = 6'd0;

    logic       mdo_ti, oe_ti, strobe_ti, err_ti;
    logic [5:0] waddr_ti;
    logic [7:0] wdata_ti, rdata_ti;
    logic       mdo_adi, oe_adi, strobe_adi, err_adi;
    logic [5:0] waddr_adi;
    logic [7:0] wdata_adi, rdata_adi;

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t q_ti[$];
    wr_t q_adi[$];
    wr_t e_ti, e_adi;
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    spi_responder #(.FORMAT(0), .GLOBAL_ADDR(7'h04), .SYNC_STAGES(2)) dut_ti (
        .clk(clk), .reset(reset), .spi_mclk(spi_mclk), .spi_cs(cs_ti), .spi_mdi(spi_mdi),
        .spi_mdo(mdo_ti), .spi_mdo_oe(oe_ti), .reg_addr(reg_addr), .reg_rdata(rdata_ti),
        .wr_strobe(strobe_ti), .wr_addr(waddr_ti), .wr_data(wdata_ti), .frame_err(err_ti)
    );

    spi_responder #(.FORMAT(1), .GLOBAL_ADDR(7'h04), .SYNC_STAGES(2)) dut_adi (
        .clk(clk), .reset(reset), .spi_mclk(spi_mclk), .spi_cs(cs_adi), .spi_mdi(spi_mdi),
        .spi_mdo(mdo_adi), .spi_mdo_oe(oe_adi), .reg_addr(reg_addr), .reg_rdata(rdata_adi),
        .wr_strobe(strobe_adi), .wr_addr(waddr_adi), .wr_data(wdata_adi), .frame_err(err_adi)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write monitor: every wr_strobe pops one expected write.
    always @(negedge clk) begin
        if (strobe_ti === 1'b1) begin
            if (q_ti.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ti_unexpected_write actual=%0h/%0h required=none", waddr_ti, wdata_ti);
            end else begin
                e_ti = q_ti.pop_front();
                chk("ti_wr_addr", 32'(waddr_ti), 32'(e_ti.a));
                chk("ti_wr_data", 32'(wdata_ti), 32'(e_ti.d));
            end
        end
        if (strobe_adi === 1'b1) begin
            if (q_adi.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL adi_unexpected_write actual=%0h/%0h required=none", waddr_adi, wdata_adi);
            end else begin
                e_adi = q_adi.pop_front();
                chk("adi_wr_addr", 32'(waddr_adi), 32'(e_adi.a));
                chk("adi_wr_data", 32'(wdata_adi), 32'(e_adi.d));
            end
        end
    end

    task automatic set_cs(input bit sel, input logic v);
        if (sel) cs_adi = v;
        else     cs_ti  = v;
    endtask

    // One byte: data and readback sampled on the rising edge, responder samples on falling.
    task automatic xfer(input bit sel, input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] oe);
        for (int i = 7; i >= 0; i--) begin
            spi_mclk = 1'b1;
            rx[i]    = sel ? mdo_adi : mdo_ti;
            oe[i]    = sel ? oe_adi : oe_ti;
            spi_mdi  = tx[i];
            #HALF;
            spi_mclk = 1'b0;
            #HALF;
        end
    endtask

    task automatic bits(input int n);
        for (int i = 0; i < n; i++) begin
            spi_mclk = 1'b1;
            spi_mdi  = 1'b1;
            #HALF;
            spi_mclk = 1'b0;
            #HALF;
        end
    endtask

    task automatic frame(input bit sel, input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, output logic [7:0] rx, output logic [7:0] oe,
                         output logic [7:0] oe0);
        logic [7:0] bs [3];
        bs[0] = b0;
        bs[1] = b1;
        bs[2] = b2;
        oe0   = 8'h00;
        @(negedge clk);
        set_cs(sel, 1'b1);
        #HALF;
        for (int i = 0; i < n; i++) begin
            xfer(sel, bs[i], rx, oe);
            if (i == 0) oe0 = oe;
        end
        #HALF;
        set_cs(sel, 1'b0);
        #200;
    endtask

    task automatic rd_chk(input string name, input bit sel, input logic [5:0] a, input logic [7:0] exp);
        reg_addr = a;
        #1;
        chk(name, 32'(sel ? rdata_adi : rdata_ti), 32'(exp));
    endtask

    task automatic push_ti(input logic [5:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        q_ti.push_back(w);
    endtask

    task automatic push_adi(input logic [5:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        q_adi.push_back(w);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx, oe, oe0, drx, doe;

        #12;
        chk("rst_oe", 32'(oe_ti), 32'd0);
        chk("rst_mdo", 32'(mdo_ti), 32'd0);
        chk("rst_strobe", 32'(strobe_ti), 32'd0);
        chk("rst_waddr", 32'(waddr_ti), 32'd0);
        chk("rst_wdata", 32'(wdata_ti), 32'd0);
        chk("rst_err", 32'(err_adi), 32'd0);
        rd_chk("rst_reg", 1'b0, 6'h2A, 8'h00);
        #20;
        @(negedge clk);
        reset = 1'b1;
        #50;

        // TI write, plus bit6 of the address byte being ignored
        push_ti(6'h05, 8'hA7);
        frame(1'b0, 2, 8'h05, 8'hA7, 8'h00, rx, oe, oe0);
        rd_chk("ti_reg5", 1'b0, 6'h05, 8'hA7);
        chk("ti_err_after_write", 32'(err_ti), 32'd0);
        push_ti(6'h06, 8'h19);
        frame(1'b0, 2, 8'h46, 8'h19, 8'h00, rx, oe, oe0);
        rd_chk("ti_reg6_bit6_ignored", 1'b0, 6'h06, 8'h19);

        // TI read
        push_ti(6'h12, 8'h3C);
        frame(1'b0, 2, 8'h12, 8'h3C, 8'h00, rx, oe, oe0);
        frame(1'b0, 2, 8'h92, 8'h00, 8'h00, rx, oe, oe0);
        chk("ti_read_data", 32'(rx), 32'h3C);
        chk("ti_read_oe_data", 32'(oe), 32'hFF);
        chk("ti_read_oe_addr", 32'(oe0), 32'h00);
        chk("ti_read_oe_after", 32'(oe_ti), 32'd0);
        chk("ti_read_err", 32'(err_ti), 32'd0);

        // ADI write, read (addr bits 7:6 ignored), then chip-address mismatch
        push_adi(6'h01, 8'h55);
        frame(1'b1, 3, 8'h09, 8'h01, 8'h55, rx, oe, oe0);
        rd_chk("adi_reg1", 1'b1, 6'h01, 8'h55);
        rd_chk("ti_reg1_untouched", 1'b0, 6'h01, 8'h00);
        frame(1'b1, 3, 8'h08, 8'hC1, 8'h00, rx, oe, oe0);
        chk("adi_read_data", 32'(rx), 32'h55);
        chk("adi_read_oe", 32'(oe), 32'hFF);
        chk("adi_err_before", 32'(err_adi), 32'd0);
        frame(1'b1, 3, 8'h0B, 8'h02, 8'h66, rx, oe, oe0);
        chk("adi_err_mismatch", 32'(err_adi), 32'd1);
        rd_chk("adi_reg2_unwritten", 1'b1, 6'h02, 8'h00);

        // Abort after 4 data bits of a write to register 7
        @(negedge clk);
        cs_ti = 1'b1;
        #HALF;
        xfer(1'b0, 8'h07, drx, doe);
        bits(4);
        #HALF;
        cs_ti = 1'b0;
        #200;
        rd_chk("abort_reg7", 1'b0, 6'h07, 8'h00);
        chk("abort_err", 32'(err_ti), 32'd1);
        push_ti(6'h08, 8'h5A);
        frame(1'b0, 2, 8'h08, 8'h5A, 8'h00, rx, oe, oe0);
        rd_chk("after_abort_reg8", 1'b0, 6'h08, 8'h5A);

        // Asynchronous reset in the middle of a read data byte
        reg_addr = 6'h12;
        @(negedge clk);
        cs_ti = 1'b1;
        #HALF;
        xfer(1'b0, 8'h92, drx, doe);
        bits(2);
        chk("midread_oe_before", 32'(oe_ti), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midread_rst_oe", 32'(oe_ti), 32'd0);
        chk("midread_rst_reg", 32'(rdata_ti), 32'h00);
        chk("midread_rst_err", 32'(err_ti), 32'd0);
        cs_ti    = 1'b0;
        spi_mclk = 1'b0;
        #50;
        @(negedge clk);
        reset = 1'b1;
        #50;
        push_ti(6'h03, 8'hC3);
        frame(1'b0, 2, 8'h03, 8'hC3, 8'h00, rx, oe, oe0);
        frame(1'b0, 2, 8'h83, 8'h00, 8'h00, rx, oe, oe0);
        chk("post_reset_read", 32'(rx), 32'hC3);
        chk("post_reset_err", 32'(err_ti), 32'd0);

        // Burst write from address 63
`ifdef SPI_RESPONDER_AUTOINC_EN
        push_ti(6'h3F, 8'h11);
        push_ti(6'h00, 8'h22);
        frame(1'b0, 3, 8'h3F, 8'h11, 8'h22, rx, oe, oe0);
        rd_chk("burst_reg63", 1'b0, 6'h3F, 8'h11);
        rd_chk("burst_reg0", 1'b0, 6'h00, 8'h22);
`else
        push_ti(6'h3F, 8'h11);
        frame(1'b0, 3, 8'h3F, 8'h11, 8'h22, rx, oe, oe0);
        rd_chk("burst_reg63", 1'b0, 6'h3F, 8'h11);
        rd_chk("burst_reg0_discarded", 1'b0, 6'h00, 8'h00);
`endif
        chk("burst_err", 32'(err_ti), 32'd0);

        #200;
        chk("ti_queue_drained", 32'(q_ti.size()), 32'd0);
        chk("adi_queue_drained", 32'(q_adi.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
